kamus_fetch_ctrl: RTL

//  Fetch sequencer between the PC/IF datapath, the $L1I request port and the ID stage.
//  - Owns the PC. Issues word fetches over a req/gnt + rvalid handshake, max 1 outstanding.
//  - Buffers responses in a small FIFO and hands them to ID under valid/ready.
//  - Handles branch/jump redirects: flushes the FIFO and kills the in-flight response.

---
 rtl/kamus_fetch_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/kamus_fetch_ctrl.sv
// kamus_fetch_ctrl
//   Fetch sequencer sitting between the PC/IF datapath, the L1I request port
//   and the ID stage. Owns the PC, issues one word fetch at a time over a
//   req/gnt + rvalid handshake, buffers responses in a small FIFO and hands
//   them to ID under valid/ready. A redirect flushes the FIFO and kills any
//   response still in flight.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   redirect_i           branch/jump taken, load PC from redirect_addr_i
//   redirect_addr_i      redirect target (bits [1:0] forced to zero)
//   imem_req_o           fetch request to L1I
//   imem_addr_o          fetch address (current PC)
//   imem_gnt_i           request accepted this cycle
//   imem_rvalid_i        response valid, one per grant, in order
//   imem_rdata_i         response instruction word
//   instr_valid_o        FIFO head valid towards ID
//   instr_data_o         FIFO head instruction word
//   instr_addr_o         FIFO head PC
//   id_ready_i           ID accepts the head entry
module kamus_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_addr_o,
    input  logic        id_ready_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        KILL
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [31:0]      pc;
    logic [31:0]      inflight_pc;
    logic [31:0]      fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic             has_credit;
    logic             not_empty;
    logic             req;
    logic             grant;
    logic             push;
    logic             pop;

    // Word alignment is implied; the low target bits carry no information.
    logic [1:0]       unused_align;
    assign unused_align = redirect_addr_i[1:0];

    // Issuing only with a free slot guarantees the eventual push never
    // meets a full FIFO, even if ID stalls meanwhile.
    assign has_credit = (count < CNT_W'(FIFO_DEPTH));
    assign not_empty  = (count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        grant      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                req   = has_credit;
                grant = has_credit & imem_gnt_i;
                // An accepted request cannot be recalled; a redirect in the
                // same cycle just marks its response for discard.
                if (grant) begin
                    state_next = redirect_i ? KILL : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    push       = ~redirect_i;
                    state_next = REQ;
                end else if (redirect_i) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A pop coinciding with a redirect is dropped by ID; the flush wins.
        pop = not_empty & id_ready_i & ~redirect_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= BOOT_ADDR;
            inflight_pc <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            fifo_addr   <= '{default: '0};
            fifo_data   <= '{default: '0};
        end else begin
            if (redirect_i) begin
                pc <= {redirect_addr_i[31:2], 2'b00};
            end else if (grant) begin
                pc <= pc + 32'd4;
            end

            if (grant) begin
                inflight_pc <= pc;
            end

            if (redirect_i) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    fifo_addr[wptr] <= inflight_pc;
                    fifo_data[wptr] <= imem_rdata_i;
                    wptr            <= wptr + PTR_W'(1);
                end
                if (pop) begin
                    rptr <= rptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc;
    assign instr_valid_o = not_empty;
    assign instr_data_o  = fifo_data[rptr];
    assign instr_addr_o  = fifo_addr[rptr];

endmodule
